// File: rtl/sequence_buffer.sv
// rtl/sequence_buffer.sv - Simon sequence memory: append, valid/ready replay, random-access check port
module sequence_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          append_valid,
    input  logic [DW-1:0] append_data,
    output logic          append_ready,
    output logic [AW:0]   length,
    output logic          full,
    output logic          empty,
    input  logic          play_start,
    output logic          play_busy,
    output logic          play_valid,
    output logic [DW-1:0] play_data,
    output logic          play_last,
    input  logic          play_ready,
    input  logic          chk_en,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_valid,
    output logic [DW-1:0] chk_data,
    output logic          chk_oob
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] idx;
    logic [AW:0]   snap_len;
    logic          append_fire;
    logic          start_fire;
    logic          last_step;
    logic          advance;

    assign full         = (length == DEPTH_L);
    assign empty        = (length == '0);
    assign play_busy    = (state != IDLE);
    assign append_ready = !full && !play_busy && !clear;
    assign append_fire  = append_valid && append_ready;
    assign last_step    = ({1'b0, idx} == (snap_len - (AW+1)'(1)));
    assign play_valid   = (state == SHOW);
    assign play_last    = play_valid && last_step;

    always_comb begin
        state_next = state;
        start_fire = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (play_start && !empty) begin
                    start_fire = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = SHOW;
            SHOW: begin
                if (play_ready) begin
                    if (last_step) begin
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // clear overrides everything, including a start or step in the same cycle
        if (clear) begin
            state_next = IDLE;
            start_fire = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            length    <= '0;
            idx       <= '0;
            snap_len  <= '0;
            play_data <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                length <= '0;
            end else if (append_fire) begin
                length <= length + (AW+1)'(1);
            end
            if (start_fire) begin
                snap_len <= length;
                idx      <= '0;
            end else if (advance) begin
                idx <= idx + AW'(1);
            end
            if (state == FETCH) begin
                play_data <= mem[idx];
            end
        end
    end

    // storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (append_fire && (length < DEPTH_L)) begin
            mem[length[AW-1:0]] <= append_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_oob   <= 1'b0;
            chk_data  <= '0;
        end else begin
            chk_valid <= chk_en;
            chk_oob   <= chk_en && ({1'b0, chk_addr} >= length);
            if (chk_en) begin
                chk_data <= ({1'b0, chk_addr} < DEPTH_L) ? mem[chk_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_sequence_buffer.sv
// tb/tb_sequence_buffer.sv - directed self-checking bench for sequence_buffer
module tb_sequence_buffer;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          append_valid;
    logic [DW-1:0] append_data;
    logic          append_ready;
    logic [AW:0]   length;
    logic          full;
    logic          empty;
    logic          play_start;
    logic          play_busy;
    logic          play_valid;
    logic [DW-1:0] play_data;
    logic          play_last;
    logic          play_ready;
    logic          chk_en;
    logic [AW-1:0] chk_addr;
    logic          chk_valid;
    logic [DW-1:0] chk_data;
    logic          chk_oob;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] seq4 [4] = '{2'd3, 2'd1, 2'd0, 2'd2};

    sequence_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .append_valid(append_valid), .append_data(append_data), .append_ready(append_ready),
        .length(length), .full(full), .empty(empty),
        .play_start(play_start), .play_busy(play_busy), .play_valid(play_valid),
        .play_data(play_data), .play_last(play_last), .play_ready(play_ready),
        .chk_en(chk_en), .chk_addr(chk_addr), .chk_valid(chk_valid),
        .chk_data(chk_data), .chk_oob(chk_oob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; append_valid = 1'b0; append_data = '0;
        play_start = 1'b0; play_ready = 1'b0; chk_en = 1'b0; chk_addr = '0;
        tick(); tick();
        n_checks++;
        if ({length, empty, full, append_ready, play_busy, play_valid, play_last, chk_valid, chk_oob}
            !== {6'd0, 1'b1, 1'b0, 1'b1, 5'b0}) begin
            n_fail++;
            $display("FAIL reset: length=%0d empty=%b full=%b ardy=%b busy=%b pv=%b chkv=%b (want 0 1 0 1 0 0 0)",
                     length, empty, full, append_ready, play_busy, play_valid, chk_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_append_check();
        for (int i = 0; i < 4; i++) begin
            append_valid = 1'b1; append_data = seq4[i];
            tick();
        end
        append_valid = 1'b0;
        n_checks++;
        if (length !== 6'd4 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL append4: length=%0d empty=%b, want 4 0", length, empty);
        end
        for (int a = 0; a < 5; a++) begin
            chk_en = 1'b1; chk_addr = AW'(a);
            tick();
            chk_en = 1'b0;
            n_checks++;
            if (a < 4) begin
                if (chk_valid !== 1'b1 || chk_oob !== 1'b0 || chk_data !== seq4[a]) begin
                    n_fail++;
                    $display("FAIL chk_read[%0d]: valid=%b oob=%b data=%0d, want 1 0 %0d",
                             a, chk_valid, chk_oob, chk_data, seq4[a]);
                end
            end else if (chk_valid !== 1'b1 || chk_oob !== 1'b1) begin
                n_fail++;
                $display("FAIL chk_oob[4]: valid=%b oob=%b, want 1 1", chk_valid, chk_oob);
            end
        end
        tick();
        n_checks++;
        if (chk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_valid_drop: got %b want 0", chk_valid);
        end
    endtask

    task automatic test_playback();
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (play_busy !== 1'b1 || play_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL play_fetch[%0d]: busy=%b valid=%b, want 1 0", k, play_busy, play_valid);
            end
            tick();
            n_checks++;
            if (play_valid !== 1'b1 || play_data !== seq4[k] || play_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL play_show[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         k, play_valid, play_data, play_last, seq4[k], (k == 3));
            end
            tick();
        end
        n_checks++;
        if (play_busy !== 1'b0 || play_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL play_end: busy=%b valid=%b, want 0 0", play_busy, play_valid);
        end
    endtask

    task automatic test_stall();
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            play_ready = (k != 1);
            tick();
            if (k == 1) begin
                for (int s = 0; s < 5; s++) begin
                    n_checks++;
                    if (play_valid !== 1'b1 || play_data !== 2'd1 || play_last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall[%0d]: valid=%b data=%0d last=%b, want 1 1 0",
                                 s, play_valid, play_data, play_last);
                    end
                    tick();
                end
                play_ready = 1'b1;
            end
            n_checks++;
            if (play_valid !== 1'b1 || play_data !== seq4[k]) begin
                n_fail++;
                $display("FAIL stall_stream[%0d]: valid=%b data=%0d, want 1 %0d",
                         k, play_valid, play_data, seq4[k]);
            end
            tick();
        end
        n_checks++;
        if (play_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: busy=%b want 0", play_busy);
        end
    endtask

    task automatic test_busy_block();
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        append_valid = 1'b1; append_data = 2'd1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                append_valid = 1'b0; play_start = 1'b0;
            end
            n_checks++;
            if (append_ready !== 1'b0 || length !== 6'd4) begin
                n_fail++;
                $display("FAIL busy_append[%0d]: ardy=%b length=%0d, want 0 4", k, append_ready, length);
            end
            tick();
            n_checks++;
            if (play_valid !== 1'b1 || play_data !== seq4[k]) begin
                n_fail++;
                $display("FAIL busy_restart[%0d]: valid=%b data=%0d, want 1 %0d",
                         k, play_valid, play_data, seq4[k]);
            end
            tick();
        end
        n_checks++;
        if (play_busy !== 1'b0 || length !== 6'd4) begin
            n_fail++;
            $display("FAIL busy_end: busy=%b length=%0d, want 0 4", play_busy, length);
        end
    endtask

    task automatic test_full();
        for (int i = 4; i < DEPTH; i++) begin
            append_valid = 1'b1; append_data = DW'(i % 4);
            tick();
        end
        n_checks++;
        if (length !== 6'd32 || full !== 1'b1 || append_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: length=%0d full=%b ardy=%b, want 32 1 0", length, full, append_ready);
        end
        append_data = 2'd1;
        tick();
        append_valid = 1'b0;
        n_checks++;
        if (length !== 6'd32) begin
            n_fail++;
            $display("FAIL full_sat: length=%0d want 32", length);
        end
        chk_en = 1'b1; chk_addr = 5'd31;
        tick();
        n_checks++;
        if (chk_data !== 2'd3 || chk_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL full_mem31: data=%0d oob=%b, want 3 0", chk_data, chk_oob);
        end
        chk_addr = 5'd0;
        tick();
        chk_en = 1'b0;
        n_checks++;
        if (chk_data !== 2'd3 || chk_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL full_mem0: data=%0d oob=%b, want 3 0", chk_data, chk_oob);
        end
    endtask

    task automatic test_clear_reset();
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        tick();
        n_checks++;
        if (play_valid !== 1'b1 || play_data !== 2'd3) begin
            n_fail++;
            $display("FAIL clr_show: valid=%b data=%0d, want 1 3", play_valid, play_data);
        end
        clear = 1'b1; append_valid = 1'b1; append_data = 2'd2; chk_en = 1'b1; chk_addr = 5'd0;
        #1;
        n_checks++;
        if (append_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ardy: got %b want 0", append_ready);
        end
        tick();
        clear = 1'b0; append_valid = 1'b0; chk_en = 1'b0;
        n_checks++;
        if (length !== 6'd0 || play_valid !== 1'b0 || play_busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL clear: length=%0d valid=%b busy=%b empty=%b, want 0 0 0 1",
                     length, play_valid, play_busy, empty);
        end
        n_checks++;
        if (chk_valid !== 1'b1 || chk_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_chk: valid=%b oob=%b, want 1 0", chk_valid, chk_oob);
        end
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        n_checks++;
        if (play_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_empty_start: busy=%b want 0", play_busy);
        end
        append_valid = 1'b1; append_data = 2'd2;
        tick();
        append_data = 2'd1;
        tick();
        append_valid = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        n_checks++;
        if (play_busy !== 1'b1 || play_valid !== 1'b0 || length !== 6'd2) begin
            n_fail++;
            $display("FAIL rst_fetch: busy=%b valid=%b length=%0d, want 1 0 2", play_busy, play_valid, length);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (length !== 6'd0 || play_busy !== 1'b0 || play_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: length=%0d busy=%b valid=%b empty=%b, want 0 0 0 1",
                     length, play_busy, play_valid, empty);
        end
        tick();
        rst_n = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        n_checks++;
        if (play_busy !== 1'b0 || length !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_empty_start: busy=%b length=%0d, want 0 0", play_busy, length);
        end
    endtask

    initial begin
        test_reset();
        test_append_check();
        test_playback();
        test_stall();
        test_busy_block();
        test_full();
        test_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
